// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: parity codes, FSM states, defaults.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package uart_pkg;

    // Parity select codes forwarded unchanged to the transmitter's Par input.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // Cycles allowed between tx_start and tx_is_active before a frame is abandoned.
    localparam int START_TO_DEF = 64;

    // Arbiter frame-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_ACT  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request bit at or after the pointer, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_vld
);

    int              sum;
    logic [ID_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit at/after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = 0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = ID_W'(sum);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one transmitter_fsm between N_REQ byte requesters with round-robin grant.
// Latency: req->ack 1 cycle, ack->tx_start 1 cycle, tx_done->done 1 cycle.
// Backpressure: requests are held until ack; one frame in flight, others wait in req.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int START_TO = START_TO_DEF,
    parameter int ID_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic                 cfg_d_num,
    input  logic                 cfg_s_num,
    input  logic [1:0]           cfg_par,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [7:0]           tx_d_in,
    output logic                 tx_ready,
    output logic                 tx_start,
    output logic                 tx_D_num,
    output logic                 tx_S_num,
    output logic [1:0]           tx_Par,
    input  logic                 tx_done,
    input  logic                 tx_is_active,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id
);

    localparam int CNT_W = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             d_num_q, d_num_d;
    logic             s_num_q, s_num_d;
    logic [1:0]       par_q, par_d;
    logic             ready_q, ready_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic [ID_W-1:0]  arb_idx;
    logic             arb_vld;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Next-state, datapath snapshot and one-cycle pulse generation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        d_num_d = d_num_q;
        s_num_d = s_num_q;
        par_d   = par_q;
        ready_d = ready_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    // Byte and frame config are captured only here; later
                    // changes on req_data/cfg_* do not touch this frame.
                    grant_d        = arb_idx;
                    data_d         = req_data[{arb_idx, 3'b000} +: 8];
                    d_num_d        = cfg_d_num;
                    s_num_d        = cfg_s_num;
                    par_d          = cfg_par;
                    ack_d[arb_idx] = 1'b1;
                    ptr_d          = (arb_idx == ID_LAST) ? '0 : arb_idx + 1'b1;
                    state_d        = ST_LOAD;
                end
            end

            ST_LOAD: begin
                ready_d = 1'b1;
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_ACT;
            end

            ST_WAIT_ACT: begin
                // A frame short enough to finish before is_active is seen
                // still counts as delivered, so tx_done is checked first.
                if (tx_done) begin
                    done_d[grant_q] = 1'b1;
                    ready_d         = 1'b0;
                    state_d         = ST_IDLE;
                end else if (tx_is_active) begin
                    ready_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d[grant_q] = 1'b1;
                    ready_d        = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (tx_done) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = ST_IDLE;
                end
            end

            default: begin
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            d_num_q <= 1'b0;
            s_num_q <= 1'b0;
            par_q   <= PAR_NONE;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            d_num_q <= d_num_d;
            s_num_q <= s_num_d;
            par_q   <= par_d;
            ready_q <= ready_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_d_in  = data_q;
    assign tx_ready = ready_q;
    assign tx_start = start_q;
    assign tx_D_num = d_num_q;
    assign tx_S_num = s_num_q;
    assign tx_Par   = par_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int START_TO = 64;
    localparam int N_CYC    = 6000;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [8*N_REQ-1:0]  req_data;
    logic                cfg_d_num;
    logic                cfg_s_num;
    logic [1:0]          cfg_par;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic [7:0]          tx_d_in;
    logic                tx_ready;
    logic                tx_start;
    logic                tx_D_num;
    logic                tx_S_num;
    logic [1:0]          tx_Par;
    logic                tx_done;
    logic                tx_is_active;
    logic                busy;
    logic [ID_W-1:0]     grant_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ    (N_REQ),
        .START_TO (START_TO),
        .ID_W     (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .cfg_d_num    (cfg_d_num),
        .cfg_s_num    (cfg_s_num),
        .cfg_par      (cfg_par),
        .ack          (ack),
        .done         (done),
        .err          (err),
        .tx_d_in      (tx_d_in),
        .tx_ready     (tx_ready),
        .tx_start     (tx_start),
        .tx_D_num     (tx_D_num),
        .tx_S_num     (tx_S_num),
        .tx_Par       (tx_Par),
        .tx_done      (tx_done),
        .tx_is_active (tx_is_active),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: last granted frame and its timeline, in cycle numbers.
    bit               have;      // a frame has been granted since the last reset
    int               own;       // owner of that frame
    int               g;         // cycle whose closing edge granted it
    int               s;         // cycle in which tx_start is expected
    int               e;         // cycle of done/err; arbiter free from here
    int               rdy_end;   // last cycle with tx_ready high
    int               mode;      // 0 normal, 1 fast (no is_active), 2 never active
    int               a_dly;
    int               len;
    int               f_dly;
    int               ptr;
    int               drop_k;
    int               drop_at;
    int               quiet_until;
    bit               want_rst;
    logic [7:0]       x_data;
    logic             x_dn;
    logic             x_sn;
    logic [1:0]       x_par;
    logic [N_REQ-1:0] pend;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        logic [N_REQ-1:0] oh, x_ack, x_done, x_err;
        logic             x_start, x_ready, x_busy;
        int               x_gid;
        logic [7:0]       e_data;
        logic             e_dn, e_sn;
        logic [1:0]       e_par;
        oh = '0; x_ack = '0; x_done = '0; x_err = '0;
        x_start = 1'b0; x_ready = 1'b0; x_busy = 1'b0; x_gid = 0;
        e_data = 8'h00; e_dn = 1'b0; e_sn = 1'b0; e_par = PAR_NONE;
        if (have) begin
            oh[own] = 1'b1;
            if (c == g + 1) x_ack = oh;
            if (c == e && mode != 2) x_done = oh;
            if (c == e && mode == 2) x_err = oh;
            x_start = (c == s);
            x_ready = (c >= s && c <= rdy_end);
            x_busy  = (c > g && c < e);
            x_gid   = own;
            e_data  = x_data;
            e_dn    = x_dn;
            e_sn    = x_sn;
            e_par   = x_par;
        end
        check_val("ack", 32'(ack), 32'(x_ack));
        check_val("done", 32'(done), 32'(x_done));
        check_val("err", 32'(err), 32'(x_err));
        check_val("tx_start", 32'(tx_start), 32'(x_start));
        check_val("tx_ready", 32'(tx_ready), 32'(x_ready));
        check_val("busy", 32'(busy), 32'(x_busy));
        check_val("grant_id", 32'(grant_id), 32'(x_gid));
        check_val("tx_d_in", 32'(tx_d_in), 32'(e_data));
        check_val("tx_D_num", 32'(tx_D_num), 32'(e_dn));
        check_val("tx_S_num", 32'(tx_S_num), 32'(e_sn));
        check_val("tx_Par", 32'(tx_Par), 32'(e_par));
    endtask

    task automatic drive_cycle(input int c);
        bit do_rst;
        int k;
        int idx;
        int r;
        do_rst = (c < 2);
        if (c == 1500 || c == 3500) want_rst = 1'b1;
        if (want_rst && have && mode == 0 && c > s + a_dly && c < s + a_dly + len) begin
            do_rst   = 1'b1;
            want_rst = 1'b0;
        end

        // Transmitter behaviour for the frame in flight.
        tx_is_active = 1'b0;
        tx_done      = 1'b0;
        if (have && c >= s) begin
            if (mode == 0) begin
                tx_is_active = (c >= s + a_dly && c <= s + a_dly + len);
                tx_done      = (c == s + a_dly + len);
            end else if (mode == 1) begin
                tx_done = (c == s + f_dly);
            end
        end

        // Requesters: drop after ack, directed openers, then random arrivals.
        if (c == drop_at) pend[drop_k] = 1'b0;
        if (c == 5) pend[0] = 1'b1;
        if (c == 80) pend = 4'b1111;
        if (c >= 300 && c > quiet_until && $urandom_range(0, 5) == 0) begin
            idx = $urandom_range(0, N_REQ - 1);
            pend[idx] = 1'b1;
        end
        for (int i = 0; i < N_REQ; i++) req_data[8*i +: 8] = 8'($urandom);
        cfg_d_num = 1'($urandom_range(0, 1));
        cfg_s_num = 1'($urandom_range(0, 1));
        cfg_par   = 2'($urandom_range(0, 2));
        if (c == 5) begin
            req_data[7:0] = 8'hDC;
            cfg_par       = PAR_EVEN;
        end

        if (do_rst) begin
            have    = 1'b0;
            ptr     = 0;
            e       = c + 1;
            drop_at = -1;
            if (c >= 2) begin
                pend        = 4'b0100;
                quiet_until = c + 1;
            end else begin
                pend = '0;
            end
        end
        rst = do_rst;
        req = pend;

        // Grant decision: first pending requester at or after the pointer.
        if (!do_rst && c >= e && pend != '0) begin
            k = -1;
            for (int i = 0; i < N_REQ; i++) begin
                idx = (ptr + i) % N_REQ;
                if (k < 0 && pend[idx]) k = idx;
            end
            own     = k;
            g       = c;
            s       = c + 2;
            ptr     = (k + 1) % N_REQ;
            drop_k  = k;
            drop_at = c + 1;
            x_data  = req_data[8*k +: 8];
            x_dn    = cfg_d_num;
            x_sn    = cfg_s_num;
            x_par   = cfg_par;
            have    = 1'b1;
            a_dly   = ($urandom_range(0, 7) == 0) ? START_TO - 1 : $urandom_range(0, 5);
            len     = $urandom_range(1, 12);
            f_dly   = $urandom_range(0, 4);
            r       = $urandom_range(0, 7);
            if (c < 300) begin
                mode  = 0;
                a_dly = $urandom_range(0, 5);
            end else begin
                mode = (r == 0) ? 2 : (r <= 2) ? 1 : 0;
            end
            if (mode == 0) begin
                e       = s + a_dly + len + 1;
                rdy_end = s + a_dly;
            end else if (mode == 1) begin
                e       = s + f_dly + 1;
                rdy_end = s + f_dly;
            end else begin
                e       = s + START_TO;
                rdy_end = s + START_TO - 1;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        req          = '0;
        req_data     = '0;
        cfg_d_num    = 1'b0;
        cfg_s_num    = 1'b0;
        cfg_par      = PAR_NONE;
        tx_done      = 1'b0;
        tx_is_active = 1'b0;
        have         = 1'b0;
        own          = 0;
        g            = 0;
        s            = 0;
        e            = 0;
        rdy_end      = 0;
        mode         = 0;
        a_dly        = 0;
        len          = 1;
        f_dly        = 0;
        ptr          = 0;
        drop_k       = 0;
        drop_at      = -1;
        quiet_until  = 0;
        want_rst     = 1'b0;
        x_data       = '0;
        x_dn         = 1'b0;
        x_sn         = 1'b0;
        x_par        = PAR_NONE;
        pend         = '0;
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            cyc = c;
            if (c > 0) check_cycle(c);
            drive_cycle(c);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one transmitter_fsm between N byte requesters. It grants one requester and latches its byte. It also snapshots the frame configuration, fires the transmitter's ready/tx_start handshake, and tracks the frame through is_active/tx_done. Completion or failure is reported back to the owning requester. It sits between the application/host side and transmitter_fsm, above the baud generator.

Parameters:
N_REQ, 4, number of requesters (2..8)
START_TO, 64, clk cycles allowed between tx_start and tx_is_active rising before the frame is abandoned
ID_W, 2, width of grant index; must equal clog2(N_REQ)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester request level; held until ack
req_data  input  8*N_REQ  byte for requester k at [8k+7:8k]
cfg_d_num  input  1  data-length select, passed to transmitter D_num
cfg_s_num  input  1  stop-bit select, passed to S_num
cfg_par  input  2  parity select, passed to Par
ack  output  N_REQ  one-cycle pulse: byte k accepted (latched)
done  output  N_REQ  one-cycle pulse: frame k fully transmitted
err  output  N_REQ  one-cycle pulse: frame k abandoned (start timeout)
tx_d_in  output  8  byte to transmitter
tx_ready  output  1  transmitter ready
tx_start  output  1  transmitter tx_start
tx_D_num  output  1  latched cfg_d_num
tx_S_num  output  1  latched cfg_s_num
tx_Par  output  2  latched cfg_par
tx_done  input  1  transmitter frame-complete pulse
tx_is_active  input  1  transmitter busy level
busy  output  1  high in any state but IDLE
grant_id  output  ID_W  index of current owner; valid while busy

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; ack/done/err=0; tx_ready=0, tx_start=0, tx_d_in=0; tx_D_num=0, tx_S_num=0, tx_Par=0; busy=0; grant_id=0; RR pointer=0 (requester 0 highest priority first).
- States: IDLE, LOAD, WAIT_ACT, WAIT_DONE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the RR pointer, wrapping modulo N_REQ.
  - On that edge: latch req_data slice into tx_d_in, latch cfg_* into tx_*, set grant_id, pulse ack[k] for one cycle, go to LOAD.
  - The RR pointer becomes k+1 mod N_REQ.
- LOAD: tx_ready=1 and tx_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_ACT.
- WAIT_ACT:
  - tx_ready is held 1 and tx_start is 0.
  - The counter increments each cycle.
  - tx_is_active=1 goes to WAIT_DONE.
  - If the counter reaches START_TO-1 without is_active: pulse err[grant_id], drop tx_ready, go to IDLE.
  - tx_done seen here (fast frame) is treated as completion: pulse done, go to IDLE.
- WAIT_DONE: tx_ready=0. A tx_done pulse produces done[grant_id] on the next cycle, then IDLE. There is no timeout in this state.
- Latency:
  - req to ack: 1 cycle when idle.
  - ack to tx_start: 1 cycle.
  - tx_done to done: 1 cycle.
  - Back-to-back frames: minimum one IDLE cycle between done and the next ack.
- Config is sampled only at grant. cfg changes mid-frame have no effect on the frame in flight.
- The granted requester's req may drop after ack; this has no effect. A req that drops before grant is simply not served.
- Simultaneous requests: strict round-robin from the pointer. No requester waits more than N_REQ-1 frames.
- ack, done and err are mutually exclusive per cycle and one-hot at most.
- rst mid-frame returns to the reset values immediately. No done or err is emitted for the aborted frame, and the transmitter sees tx_start=0.

Decomposition:
- Package uart_pkg: parity codes PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10; state encoding for IDLE/LOAD/WAIT_ACT/WAIT_DONE; default START_TO.
- Sub-module rr_arbiter: combinational first-set-at-or-after-pointer search returning grant index and valid, parameterised by N_REQ.
- Top-level FSM, timeout counter and datapath latches stay in uart_tx_arbiter.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hDC, cfg_par=2'b10 -> ack[0] next cycle; tx_start one cycle with tx_d_in=8'hDC, tx_Par=2'b10; model tx_done -> done[0] one cycle later; busy back to 0.
- All four requesting, pointer 0: req=4'b1111 held -> grant order 0,1,2,3,0; each ack precedes matching done; never two frames overlap.
- Wrap fairness: pointer at 3, req=4'b1001 -> requester 3 served, then requester 0; the pointer wraps to 0, then to 1.
- Start timeout: model never raises tx_is_active -> err[grant_id] exactly START_TO cycles after tx_start; no done; next pending request is then served.
- Config snapshot: cfg_d_num toggles and cfg_par changes 2'b10->2'b00 during WAIT_DONE -> tx_D_num and tx_Par unchanged until the next grant.
- Reset mid-frame: rst=1 for one cycle in WAIT_DONE -> all outputs at reset values the next cycle; no done or err for the aborted frame; a later req=4'b0100 is granted normally.
